// File: rtl/branch_pkg.sv
// Shared types for the branch resolve driver: FSM state encoding and predictor-facing widths.
package branch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    CHK  = 2'd2,
    UPD  = 2'd3
  } state_e;

  localparam int STATE_W = 2;
  localparam int PRED_W  = 1;

endpackage

// File: rtl/branch_resolve_driver_if.sv
// Execute-side, predictor-side and statistics signals of the branch resolve driver.
// master = the driver itself; slave = execute stage / predictor / stats consumer.
interface branch_resolve_driver_if
  import branch_pkg::*;
#(
  parameter int CNT_W = 16
) ();

  logic              in_valid;
  logic              in_taken;
  logic              in_ready;
  logic              request;
  logic              result;
  logic              taken;
  logic [PRED_W-1:0] prediction;
  logic              grade_valid;
  logic              grade_hit;
  logic              stats_clr;
  logic [CNT_W-1:0]  branch_cnt;
  logic [CNT_W-1:0]  miss_cnt;

  modport master (
    input  in_valid, in_taken, prediction, stats_clr,
    output in_ready, request, result, taken, grade_valid, grade_hit, branch_cnt, miss_cnt
  );

  modport slave (
    output in_valid, in_taken, prediction, stats_clr,
    input  in_ready, request, result, taken, grade_valid, grade_hit, branch_cnt, miss_cnt
  );

endinterface

// File: rtl/outcome_fifo.sv
// DEPTH x 1-bit outcome buffer; head readable combinationally, push/pop take effect on the edge.
// full_o/empty_o come from the registered count, so a pop frees a slot only from the next cycle.
module outcome_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  logic push_dat_i,
  input  logic pop_i,
  output logic pop_dat_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign do_push   = push_i && !full_o;
  assign do_pop    = pop_i && !empty_o;
  assign pop_dat_o = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/branch_resolve_driver.sv
// Pops resolved branch outcomes, requests a prediction, grades it and trains the predictor.
// One branch per 4 cycles (REQ/CHK/UPD after the IDLE pop); execute is stalled via in_ready.
module branch_resolve_driver
  import branch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input logic                    clk,
  input logic                    rst,
  branch_resolve_driver_if.master bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic             cur_taken_q, cur_taken_d;
  logic             request_q, request_d;
  logic             result_q, result_d;
  logic             taken_q, taken_d;
  logic             grade_valid_q, grade_valid_d;
  logic             grade_hit_q, grade_hit_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

  logic fifo_pop;
  logic fifo_dat;
  logic fifo_full;
  logic fifo_empty;

  outcome_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (bus.in_valid),
    .push_dat_i (bus.in_taken),
    .pop_i      (fifo_pop),
    .pop_dat_o  (fifo_dat),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    cur_taken_d = cur_taken_q;
    fifo_pop    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          cur_taken_d = fifo_dat;
          state_d     = REQ;
        end
      end
      REQ:     state_d = CHK;
      CHK:     state_d = UPD;
      UPD:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered off the next state; UPD is only entered from CHK,
    // which is exactly the cycle the predictor's answer is on the bus.
    request_d     = (state_d == REQ);
    result_d      = (state_d == UPD);
    taken_d       = (state_d == UPD) && cur_taken_q;
    grade_valid_d = (state_d == UPD);
    grade_hit_d   = (state_d == UPD) && (bus.prediction == cur_taken_q);
  end

  always_comb begin
    branch_cnt_d = branch_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    if (bus.stats_clr) begin
      branch_cnt_d = '0;
      miss_cnt_d   = '0;
    end else if (grade_valid_q) begin
      if (branch_cnt_q != CNT_MAX) branch_cnt_d = branch_cnt_q + CNT_W'(1);
      if (!grade_hit_q && (miss_cnt_q != CNT_MAX)) miss_cnt_d = miss_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cur_taken_q   <= 1'b0;
      request_q     <= 1'b0;
      result_q      <= 1'b0;
      taken_q       <= 1'b0;
      grade_valid_q <= 1'b0;
      grade_hit_q   <= 1'b0;
      branch_cnt_q  <= '0;
      miss_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      cur_taken_q   <= cur_taken_d;
      request_q     <= request_d;
      result_q      <= result_d;
      taken_q       <= taken_d;
      grade_valid_q <= grade_valid_d;
      grade_hit_q   <= grade_hit_d;
      branch_cnt_q  <= branch_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
    end
  end

  assign bus.in_ready    = !fifo_full;
  assign bus.request     = request_q;
  assign bus.result      = result_q;
  assign bus.taken       = taken_q;
  assign bus.grade_valid = grade_valid_q;
  assign bus.grade_hit   = grade_hit_q;
  assign bus.branch_cnt  = branch_cnt_q;
  assign bus.miss_cnt    = miss_cnt_q;

endmodule

// File: tb/tb_branch_resolve_driver.sv
// Directed bench: dut_a (CNT_W=16) talks to a 2-bit-counter predictor model,
// dut_b (CNT_W=2) sees a predictor stuck at 0 to exercise counter saturation.
module tb_branch_resolve_driver;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_resolve_driver_if #(.CNT_W(16)) bus_a ();
  branch_resolve_driver_if #(.CNT_W(2))  bus_b ();

  branch_resolve_driver #(.DEPTH(4), .CNT_W(16)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  branch_resolve_driver #(.DEPTH(4), .CNT_W(2))  dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  int n_chk  = 0;
  int n_pass = 0;
  int viol_a = 0, viol_b = 0;
  int res_a = 0, grd_a = 0, res_b = 0, grd_b = 0;
  logic q_taken_a[$];
  logic q_hit_a[$];
  logic q_pred_a[$];

  // Predictor model, not touched by rst: latch on request, train on result.
  logic [1:0] pctr;
  logic       pred_q;
  logic       pload;
  logic [1:0] pload_val;
  always @(posedge clk) begin
    if (pload) pctr <= pload_val;
    else if (bus_a.result)
      pctr <= bus_a.taken ? ((pctr == 2'b11) ? 2'b11 : pctr + 2'b01)
                          : ((pctr == 2'b00) ? 2'b00 : pctr - 2'b01);
    if (bus_a.request) pred_q <= pctr[1];
  end
  assign bus_a.prediction = pred_q;
  assign bus_b.prediction = 1'b0;

  always @(negedge clk) begin
    if (bus_a.request && bus_a.result) viol_a++;
    if (!bus_a.result && bus_a.taken) viol_a++;
    if (bus_b.request && bus_b.result) viol_b++;
    if (!bus_b.result && bus_b.taken) viol_b++;
    if (bus_a.result) begin res_a++; q_taken_a.push_back(bus_a.taken); end
    if (bus_a.grade_valid) begin
      grd_a++;
      q_hit_a.push_back(bus_a.grade_hit);
      q_pred_a.push_back(bus_a.prediction);
    end
    if (bus_b.result) res_b++;
    if (bus_b.grade_valid) grd_b++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic push_a(input logic t);
    int k = 0;
    bus_a.in_valid = 1'b1;
    bus_a.in_taken = t;
    while (!bus_a.in_ready && k < 100) begin @(negedge clk); k++; end
    if (k >= 100) chk("push_a_timeout", 0, 1);
    @(negedge clk);
    bus_a.in_valid = 1'b0;
  endtask

  task automatic wait_grd_a(input int target);
    int k = 0;
    while (grd_a < target && k < 400) begin @(negedge clk); k++; end
    if (k >= 400) chk("wait_grd_a_timeout", grd_a, target);
  endtask

  task automatic clr_a();
    bus_a.stats_clr = 1'b1;
    tick(1);
    bus_a.stats_clr = 1'b0;
  endtask

  task automatic set_pred(input logic [1:0] v);
    pload = 1'b1; pload_val = v;
    tick(1);
    pload = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_pred;
    logic [3:0] exp_hit;
    logic [5:0] pat4;
    int base, g0, i, k, first_low;

    rst = 1'b1;
    pload = 1'b0; pload_val = 2'b00;
    bus_a.in_valid = 0; bus_a.in_taken = 0; bus_a.stats_clr = 0;
    bus_b.in_valid = 0; bus_b.in_taken = 0; bus_b.stats_clr = 0;
    tick(2);
    chk("rst_in_ready", bus_a.in_ready, 1);
    chk("rst_request", bus_a.request, 0);
    chk("rst_branch_cnt", bus_a.branch_cnt, 0);
    rst = 1'b0;
    set_pred(2'b00);

    // Test 1: reset while the branch sits in CHK.
    push_a(1'b1);          // now in the pop cycle
    tick(1);
    chk("t1_req", bus_a.request, 1);
    tick(1);               // CHK
    rst = 1'b1;
    tick(1);
    chk("t1_request", bus_a.request, 0);
    chk("t1_result", bus_a.result, 0);
    chk("t1_grade_valid", bus_a.grade_valid, 0);
    chk("t1_in_ready", bus_a.in_ready, 1);
    chk("t1_miss_cnt", bus_a.miss_cnt, 0);
    rst = 1'b0;
    tick(8);
    chk("t1_no_grade", grd_a, 0);
    chk("t1_no_result", res_a, 0);

    // Test 2: single taken branch, predictor strongly taken.
    set_pred(2'b11);
    push_a(1'b1);
    chk("t2_req_pop_cycle", bus_a.request, 0);
    tick(1);
    chk("t2_req", bus_a.request, 1);
    tick(1);
    chk("t2_chk_req", bus_a.request, 0);
    chk("t2_chk_res", bus_a.result, 0);
    tick(1);
    chk("t2_result", bus_a.result, 1);
    chk("t2_taken", bus_a.taken, 1);
    chk("t2_grade_valid", bus_a.grade_valid, 1);
    chk("t2_grade_hit", bus_a.grade_hit, 1);
    tick(1);
    chk("t2_branch_cnt", bus_a.branch_cnt, 1);
    chk("t2_miss_cnt", bus_a.miss_cnt, 0);
    chk("t2_result_end", bus_a.result, 0);

    // Test 3: training trace T,T,T,N from counter 00.
    clr_a();
    set_pred(2'b00);
    base = q_hit_a.size();
    g0 = grd_a;
    exp_pred = 4'b1100;
    exp_hit  = 4'b0100;
    push_a(1'b1); push_a(1'b1); push_a(1'b1); push_a(1'b0);
    wait_grd_a(g0 + 4);
    tick(2);
    for (int j = 0; j < 4; j++) begin
      if (base + j < q_hit_a.size()) begin
        chk($sformatf("t3_pred%0d", j), q_pred_a[base+j], exp_pred[j]);
        chk($sformatf("t3_hit%0d", j), q_hit_a[base+j], exp_hit[j]);
      end else chk($sformatf("t3_missing%0d", j), base + j, q_hit_a.size());
    end
    chk("t3_branch_cnt", bus_a.branch_cnt, 4);
    chk("t3_miss_cnt", bus_a.miss_cnt, 3);

    // Test 4: six outcomes with in_valid held against a 4-deep FIFO.
    // The first entry is popped the cycle after it lands, so the FIFO fills on the fifth accept.
    clr_a();
    pat4 = 6'b101101;
    base = q_taken_a.size();
    g0 = grd_a;
    i = 0; k = 0; first_low = -1;
    bus_a.in_valid = 1'b1;
    while (i < 6 && k < 200) begin
      bus_a.in_taken = pat4[i];
      if (bus_a.in_ready) i++;
      else if (first_low < 0) first_low = i;
      @(negedge clk); k++;
    end
    bus_a.in_valid = 1'b0;
    chk("t4_accepted", i, 6);
    chk("t4_ready_low_after", first_low, 5);
    wait_grd_a(g0 + 6);
    tick(10);
    chk("t4_graded", grd_a - g0, 6);
    for (int j = 0; j < 6; j++) begin
      if (base + j < q_taken_a.size())
        chk($sformatf("t4_order%0d", j), q_taken_a[base+j], pat4[j]);
    end
    chk("t4_branch_cnt", bus_a.branch_cnt, 6);

    // Clear wins over a live increment on a grade cycle.
    push_a(1'b0);
    k = 0;
    while (!bus_a.grade_valid && k < 50) begin @(negedge clk); k++; end
    if (k >= 50) chk("t4_clr_wait_timeout", 0, 1);
    clr_a();
    chk("t4_clr_branch", bus_a.branch_cnt, 0);
    chk("t4_clr_miss", bus_a.miss_cnt, 0);

    // Test 5: CNT_W=2 saturation with five misses, then clear on a grade cycle.
    i = 0; k = 0;
    bus_b.in_valid = 1'b1;
    bus_b.in_taken = 1'b1;
    while (i < 5 && k < 200) begin
      if (bus_b.in_ready) i++;
      @(negedge clk); k++;
    end
    bus_b.in_valid = 1'b0;
    k = 0;
    while (grd_b < 5 && k < 400) begin @(negedge clk); k++; end
    if (k >= 400) chk("t5_wait_timeout", grd_b, 5);
    tick(2);
    chk("t5_branch_sat", bus_b.branch_cnt, 3);
    chk("t5_miss_sat", bus_b.miss_cnt, 3);
    bus_b.in_valid = 1'b1;
    bus_b.in_taken = 1'b0;
    tick(1);
    bus_b.in_valid = 1'b0;
    k = 0;
    while (!bus_b.grade_valid && k < 50) begin @(negedge clk); k++; end
    if (k >= 50) chk("t5_clr_wait_timeout", 0, 1);
    bus_b.stats_clr = 1'b1;
    tick(1);
    bus_b.stats_clr = 1'b0;
    chk("t5_clr_branch", bus_b.branch_cnt, 0);
    chk("t5_clr_miss", bus_b.miss_cnt, 0);

    // Protocol rules accumulated over the whole run.
    tick(4);
    chk("proto_a_violations", viol_a, 0);
    chk("proto_b_violations", viol_b, 0);
    chk("proto_a_result_vs_grade", res_a, grd_a);
    chk("proto_b_result_vs_grade", res_b, grd_b);
    chk("proto_b_total_grades", grd_b, 6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
